// File: rtl/uart_prog_loader.sv
// UART boot loader: receives a length-prefixed image over rx and emits one
// 32-bit write per 4 received bytes, then holds upg_done_o high.
module uart_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rx,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              upg_err_o
);

    localparam int unsigned      CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0]  HalfCnt  = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0]  LastCnt  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [31:0]      MaxWords = 32'(1) << ADDR_W;
    localparam logic [ADDR_W:0]  MaxN     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  IdxOne   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {LdHdr, LdLoad, LdDone} ld_state_e;

    rx_state_e         rx_state_q, rx_state_d;
    ld_state_e         ld_state_q, ld_state_d;
    logic              rx_s1_q, rx_s2_q;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_err;
    logic [7:0]        hdr_lo_q, hdr_lo_d;
    logic              hdr_cnt_q, hdr_cnt_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       hdr_val;
    logic [ADDR_W:0]   idx_next;

    assign hdr_val  = {rx_shift_q, hdr_lo_q};
    assign idx_next = {1'b0, word_idx_q} + IdxOne;

    // Synchronizer flops preset to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_s2_q) begin
                    rx_state_d = RxStart;
                    bit_cnt_d  = '0;
                end
            end
            RxStart: begin
                if (bit_cnt_q == HalfCnt) begin
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_s2_q ? RxIdle : RxData;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (bit_cnt_q == LastCnt) begin
                    bit_cnt_d  = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (bit_cnt_q == LastCnt) begin
                    bit_cnt_d    = '0;
                    rx_state_d   = RxIdle;
                    byte_valid_d = rx_s2_q;
                    frame_err    = !rx_s2_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
        if (!en) begin
            rx_state_d   = RxIdle;
            byte_valid_d = 1'b0;
            frame_err    = 1'b0;
        end
    end

    always_comb begin
        ld_state_d = ld_state_q;
        hdr_lo_d   = hdr_lo_q;
        hdr_cnt_d  = hdr_cnt_q;
        n_d        = n_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        word_idx_d = word_idx_q;
        wen_d      = 1'b0;
        adr_d      = adr_q;
        dat_d      = dat_q;
        done_d     = done_q;
        err_d      = err_q | frame_err;
        unique case (ld_state_q)
            LdHdr: begin
                if (byte_valid_q) begin
                    if (!hdr_cnt_q) begin
                        hdr_lo_d  = rx_shift_q;
                        hdr_cnt_d = 1'b1;
                    end else begin
                        hdr_cnt_d = 1'b0;
                        if (hdr_val == 16'd0) begin
                            ld_state_d = LdDone;
                            done_d     = 1'b1;
                        end else begin
                            n_d = ({16'd0, hdr_val} > MaxWords) ? MaxN
                                                                 : (ADDR_W + 1)'(hdr_val);
                            ld_state_d = LdLoad;
                        end
                    end
                end
            end
            LdLoad: begin
                if (byte_valid_q) begin
                    shift_d    = {rx_shift_q, shift_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wen_d = 1'b1;
                        adr_d = word_idx_q;
                        dat_d = {rx_shift_q, shift_q[31:8]};
                    end
                end
                // Index advances (or the image ends) in the strobe cycle.
                if (wen_q) begin
                    if (idx_next == n_q) begin
                        ld_state_d = LdDone;
                        done_d     = 1'b1;
                    end else begin
                        word_idx_d = idx_next[ADDR_W-1:0];
                    end
                end
            end
            LdDone: ;
            default: ld_state_d = LdHdr;
        endcase
        if (!en) begin
            ld_state_d = LdHdr;
            hdr_cnt_d  = 1'b0;
            n_d        = '0;
            byte_cnt_d = '0;
            word_idx_d = '0;
            wen_d      = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q   <= RxIdle;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            ld_state_q   <= LdHdr;
            hdr_lo_q     <= '0;
            hdr_cnt_q    <= 1'b0;
            n_q          <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            word_idx_q   <= '0;
            wen_q        <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            ld_state_q   <= ld_state_d;
            hdr_lo_q     <= hdr_lo_d;
            hdr_cnt_q    <= hdr_cnt_d;
            n_q          <= n_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            word_idx_q   <= word_idx_d;
            wen_q        <= wen_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized bench for uart_prog_loader: a byte-level image model predicts the
// write stream, and a negedge compare process checks every strobe against it.
module tb_uart_prog_loader;

    localparam int unsigned CPB = 4;
    localparam int unsigned AW  = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic          rx  = 1'b1;
    logic          upg_wen_o;
    logic [AW-1:0] upg_adr_o;
    logic [31:0]   upg_dat_o;
    logic          upg_done_o;
    logic          upg_err_o;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rx        (rx),
        .upg_wen_o (upg_wen_o),
        .upg_adr_o (upg_adr_o),
        .upg_dat_o (upg_dat_o),
        .upg_done_o(upg_done_o),
        .upg_err_o (upg_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: image header, byte buffer, expected writes.
    int             m_hdr_cnt;
    logic [7:0]     m_hdr_lo;
    int             m_n;
    bit             m_load;
    bit             m_done;
    bit             m_err;
    logic [7:0]     m_buf[$];
    int             m_widx;
    logic [46:0]    exp_q[$];
    logic [46:0]    got_q[$];
    int             wen_cnt;
    bit             prev_wen;
    bit             last_pending;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_hdr_cnt = 0;
        m_hdr_lo  = 8'h00;
        m_n       = 0;
        m_load    = 1'b0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_widx    = 0;
        m_buf.delete();
        exp_q.delete();
        got_q.delete();
        wen_cnt   = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        logic [31:0] w;
        logic [AW-1:0] a;
        if (m_done) return;
        if (!m_load) begin
            if (m_hdr_cnt == 0) begin
                m_hdr_lo  = b;
                m_hdr_cnt = 1;
            end else begin
                n = int'({b, m_hdr_lo});
                m_hdr_cnt = 0;
                if (n == 0) m_done = 1'b1;
                else begin
                    m_n    = (n > (1 << AW)) ? (1 << AW) : n;
                    m_load = 1'b1;
                end
            end
        end else begin
            m_buf.push_back(b);
            if (m_buf.size() == 4) begin
                w = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                a = AW'(m_widx);
                exp_q.push_back({a, w});
                m_buf.delete();
                m_widx++;
                if (m_widx == m_n) m_done = 1'b1;
            end
        end
    endtask

    // Drives one UART frame; caller must be aligned just after a clock edge.
    task automatic send_raw(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw(b, 1'b1);
        model_byte(b);
        tick($urandom_range(0, 6));
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_raw(b, 1'b0);
        m_err = 1'b1;
        tick($urandom_range(0, 6));
    endtask

    task automatic toggle_en();
        en = 1'b0;
        tick(3);
        check("en_low_wen", 64'(upg_wen_o), 64'd0);
        check("en_low_done", 64'(upg_done_o), 64'd0);
        check("en_low_err", 64'(upg_err_o), 64'd0);
        model_reset();
        en = 1'b1;
        tick(2);
    endtask

    // Compare process: every strobe against the model, plus protocol rules.
    always @(negedge clk) begin
        if (rst) begin
            if (last_pending) check("done_after_last", 64'(upg_done_o), 64'd1);
            last_pending = 1'b0;
            if (upg_wen_o) begin
                check("wen_single_cycle", 64'(prev_wen), 64'd0);
                check("wen_expected", 64'(exp_q.size() != 0), 64'd1);
                got_q.push_back({upg_adr_o, upg_dat_o});
                wen_cnt++;
                if (exp_q.size() != 0) begin
                    check("wen_adr", 64'(upg_adr_o), 64'(exp_q[0][46:32]));
                    check("wen_dat", 64'(upg_dat_o), 64'(exp_q[0][31:0]));
                    void'(exp_q.pop_front());
                    last_pending = (exp_q.size() == 0) && m_done;
                end
            end
            if (upg_done_o) check("done_early", 64'(exp_q.size()), 64'd0);
            if (upg_err_o) check("err_unexpected", 64'(m_err), 64'd1);
            prev_wen = upg_wen_o;
        end else begin
            prev_wen     = 1'b0;
            last_pending = 1'b0;
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] r;
        model_reset();
        #3;
        check("rst_wen", 64'(upg_wen_o), 64'd0);
        check("rst_adr", 64'(upg_adr_o), 64'd0);
        check("rst_dat", 64'(upg_dat_o), 64'd0);
        check("rst_done", 64'(upg_done_o), 64'd0);
        check("rst_err", 64'(upg_err_o), 64'd0);
        #20 rst = 1'b1;
        tick(3);
        en = 1'b1;
        tick(2);

        // Basic two-word load.
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        tick(20);
        check("basic_w0", 64'(got_q[0]), 64'({15'd0, 32'h0000_0013}));
        check("basic_w1", 64'(got_q[1]), 64'({15'd1, 32'h0010_0093}));
        check("basic_cnt", 64'(wen_cnt), 64'd2);
        check("basic_done", 64'(upg_done_o), 64'd1);
        check("basic_err", 64'(upg_err_o), 64'd0);
        check("basic_adr_hold", 64'(upg_adr_o), 64'd1);
        check("basic_dat_hold", 64'(upg_dat_o), 64'h0010_0093);
        send_byte(8'h5A);
        tick(10);
        check("done_ignores", 64'(wen_cnt), 64'd2);

        // Async reset mid-byte from the DONE state.
        fork
            send_raw(8'h55, 1'b1);
            begin
                #($urandom_range(31, 149));
                rst = 1'b0;
                #1;
                check("arst_wen", 64'(upg_wen_o), 64'd0);
                check("arst_adr", 64'(upg_adr_o), 64'd0);
                check("arst_dat", 64'(upg_dat_o), 64'd0);
                check("arst_done", 64'(upg_done_o), 64'd0);
                check("arst_err", 64'(upg_err_o), 64'd0);
            end
        join
        tick(2);
        rst = 1'b1;
        model_reset();
        tick(3);
        send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        tick(10);
        check("arst_reload_cnt", 64'(wen_cnt), 64'd1);
        check("arst_reload_done", 64'(upg_done_o), 64'd1);

        // Zero-length image.
        toggle_en();
        send_byte(8'h00); send_byte(8'h00);
        tick(10);
        check("zero_done", 64'(upg_done_o), 64'd1);
        send_byte(8'hAA);
        tick(10);
        check("zero_no_wen", 64'(wen_cnt), 64'd0);

        // Glitch, then a framing error inside a word.
        toggle_en();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'($urandom)); send_byte(8'($urandom));
        send_bad(8'($urandom));
        tick(3);
        check("ferr_flag", 64'(upg_err_o), 64'd1);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        tick(10);
        check("ferr_cnt", 64'(wen_cnt), 64'd2);
        check("ferr_done", 64'(upg_done_o), 64'd1);
        check("ferr_sticky", 64'(upg_err_o), 64'd1);

        // en abort mid-image, then a fresh one-word image.
        toggle_en();
        send_byte(8'h03); send_byte(8'h00);
        send_byte(8'($urandom)); send_byte(8'($urandom));
        tick(3);
        toggle_en();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        tick(10);
        check("abort_w0", 64'(got_q[0]), 64'({15'd0, 32'hDEAD_BEEF}));
        check("abort_cnt", 64'(wen_cnt), 64'd1);
        check("abort_done", 64'(upg_done_o), 64'd1);
        check("abort_err", 64'(upg_err_o), 64'd0);

        // Random images with occasional framing errors.
        for (int it = 0; it < 4; it++) begin
            toggle_en();
            n = $urandom_range(1, 5);
            send_byte(8'(n)); send_byte(8'h00);
            for (int b = 0; b < n * 4; b++) begin
                if ($urandom_range(0, 7) == 0) send_bad(8'($urandom));
                r = 8'($urandom);
                send_byte(r);
            end
            tick(10);
            check("rand_cnt", 64'(wen_cnt), 64'(n));
            check("rand_done", 64'(upg_done_o), 64'd1);
            check("rand_err", 64'(upg_err_o), 64'(m_err));
        end

        // Header saturation and the region bit, with a forced word index.
        toggle_en();
        send_byte(8'hFF); send_byte(8'hFF);
        tick(3);
        check("sat_count", 64'(dut.n_q), 64'd32768);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        tick(5);
        force dut.word_idx_q = 15'd16383;
        tick(2);
        release dut.word_idx_q;
        m_widx = 16383;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        tick(5);
        check("sat_region_adr", 64'(upg_adr_o), 64'd16384);
        check("sat_region_bit", 64'(upg_adr_o[14]), 64'd1);
        check("sat_not_done", 64'(upg_done_o), 64'd0);
        force dut.word_idx_q = 15'h7FFF;
        tick(2);
        release dut.word_idx_q;
        m_widx = 32767;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        tick(10);
        check("sat_last_adr", 64'(upg_adr_o), 64'h7FFF);
        check("sat_done", 64'(upg_done_o), 64'd1);
        check("sat_cnt", 64'(wen_cnt), 64'd4);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- UART boot loader that sits directly upstream of instruction fetch and the IO bridge.
- Receives a serial program image, assembles 32-bit words and emits a write stream (wen/adr/dat) plus a done level.
- adr[14] selects the region: 0 = instruction memory, 1 = data memory. The top level splits the stream on that bit.
- Runs on the CPU clock domain. The CPU is held in reset until upg_done_o is high.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- ADDR_W, 15, word-address width; maximum image size is 2^ADDR_W words.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  loader enable; level, synchronous.
- rx  in  1  UART serial input; idle high; asynchronous to clk.
- upg_wen_o  out  1  one-cycle write strobe.
- upg_adr_o  out  ADDR_W  word address of the current write.
- upg_dat_o  out  32  write data.
- upg_done_o  out  1  image fully received (level).
- upg_err_o  out  1  sticky framing-error flag.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; both FSMs go to IDLE / HDR; counters 0; rx synchronizer flops preset to 1.
- rx passes through a 2-flop synchronizer. All rx references below mean the synchronized value.
- Byte receiver FSM (states IDLE, START, DATA, STOP):
  - IDLE: on rx=0, go to START and clear the bit-timer.
  - START: at count CLKS_PER_BIT/2 (integer division), sample rx. If rx=1 it was a glitch: return to IDLE with no byte. If rx=0, go to DATA.
  - DATA: sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample.
  - STOP: sample one CLKS_PER_BIT later.
    - rx=1: byte_valid pulses for 1 cycle.
    - rx=0: byte discarded, upg_err_o set to 1 and held until reset or en=0.
  - STOP always returns to IDLE; the next start bit may be detected on the following cycle.
- Loader FSM (states HDR, LOAD, DONE):
  - HDR: collect 2 bytes, little-endian, into a 16-bit word count N.
    - N=0 goes directly to DONE.
    - N > 2^ADDR_W saturates to 2^ADDR_W.
  - LOAD: bytes fill a 4-byte shift register, little-endian (first byte = dat[7:0]).
    - On the cycle after the 4th byte_valid: upg_wen_o=1 for exactly 1 cycle, upg_dat_o={b3,b2,b1,b0}, upg_adr_o=word index (0, 1, 2, ...).
    - adr and dat stay stable until the next write.
    - After the write with index N-1, go to DONE the same cycle wen deasserts.
  - DONE: upg_done_o=1. Further rx bytes are received but ignored; no more wen.
- en=0 (any state, synchronous):
  - Both FSMs return to IDLE / HDR.
  - Word index, byte count and N cleared.
  - upg_done_o, upg_err_o and upg_wen_o forced to 0.
  - A partially received byte is dropped.
- en rising: loading starts fresh. Re-entering reload requires en toggling.
- A framing error in HDR or LOAD does not advance the byte count; the byte is lost. This is the host's responsibility; there is no retry.
- Index wrap: the word index never exceeds 2^ADDR_W-1 because of N saturation.
- Latency: last stop-bit sample -> byte_valid is 1 cycle; byte_valid -> wen is 1 cycle.

Test Plan (CLKS_PER_BIT=4, ADDR_W=15):
- Basic load:
  - Stimulus: en=1; send 02 00, then 13 00 00 00, then 93 00 10 00.
  - Required response: wen at adr 0 with dat 0x00000013; wen at adr 1 with dat 0x00100093; done=1 after the second write; exactly 2 wen pulses; err=0.
- Zero image:
  - Stimulus: send header 00 00.
  - Required response: done=1 with no wen.
  - Follow-up: further byte AA produces no wen.
- Glitch and framing error:
  - Stimulus: a 1-cycle rx low pulse.
  - Required response: no byte received.
  - Stimulus: a byte whose stop bit is 0.
  - Required response: err=1, that byte is not counted, the next good bytes complete the word normally.
- en abort:
  - Stimulus: deassert en after header plus 2 data bytes; re-enable; send 01 00 EF BE AD DE.
  - Required response: a single wen at adr 0 with dat 0xDEADBEEF; done=1; err=0.
- Async reset:
  - Stimulus: pull rst low mid-byte, at an arbitrary clk phase.
  - Required response: all outputs 0 immediately; after release the loader is in HDR.
- Saturation and region bit:
  - Stimulus: header FF FF.
  - Required response: the count saturates to 32768; the word with index 16384 appears with adr[14]=1; done after adr 0x7FFF (spot-check with a forced internal count).
